// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic GEMM engine:
// controller states, drain-length helper and the requantisation function.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int FLUSH_CYCLES = DEF_ROWS + DEF_COLS - 1;

    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    // Round half up, arithmetic shift right, then clamp to a dw-bit signed range.
    // Works in 64 bits so the rounding add cannot wrap for accumulators up to 63 bits.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input logic [31:0]        sh,
                                                     input int                 dw);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = acc;
        if (sh != 32'd0)
            v = v + (64'sd1 <<< (sh - 32'd1));
        v  = v >>> sh;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/systolic_os_array_pe.sv
// One processing element: signed MAC into a stationary accumulator, with the
// operands forwarded right (a) and down (b) on every enabled step.
module systolic_os_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clr,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] a_fwd,
    output logic signed [DATA_WIDTH-1:0] b_fwd,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            a_fwd <= '0;
            b_fwd <= '0;
        end else if (clr) begin
            acc   <= '0;
            a_fwd <= '0;
            b_fwd <= '0;
        end else if (en) begin
            acc   <= acc + ACC_WIDTH'(prod);
            a_fwd <= a;
            b_fwd <= b;
        end
    end

endmodule

// File: rtl/systolic_os_array.sv
// Output-stationary ROWS x COLS systolic GEMM with input skew, valid/ready
// operand streaming, programmable K and a requantised row-by-row drain.
module systolic_os_array
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int K_WIDTH     = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic [SHIFT_WIDTH-1:0]     shift,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_in,
    input  logic [COLS*DATA_WIDTH-1:0] b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*DATA_WIDTH-1:0] out_row,
    output logic [$clog2(ROWS)-1:0]    out_row_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int FLUSH_LEN = flush_cycles(ROWS, COLS);
    localparam int FW        = $clog2(FLUSH_LEN + 1);
    localparam int IW        = $clog2(ROWS);

    state_t                     state;
    state_t                     state_next;
    logic [K_WIDTH-1:0]         k_reg;
    logic [K_WIDTH-1:0]         beat_cnt;
    logic [SHIFT_WIDTH-1:0]     shift_reg;
    logic [FW-1:0]              flush_cnt;
    logic                       accept;
    logic                       advance;
    logic                       clear;
    logic                       last_beat;
    logic                       flush_end;
    logic                       row_xfer;
    logic                       last_row;
    logic [IW-1:0]              sel_row;
    logic [COLS*DATA_WIDTH-1:0] q_row;

    logic signed [DATA_WIDTH-1:0] a_h      [ROWS][COLS+1];
    logic signed [DATA_WIDTH-1:0] b_v      [ROWS+1][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_grid [ROWS][COLS];

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign advance   = accept || (state == FLUSH);
    assign clear     = (state == IDLE) && start;
    assign last_beat = accept && (beat_cnt == k_reg - 1'b1);
    assign flush_end = (state == FLUSH) && (flush_cnt == FW'(FLUSH_LEN - 1));
    assign row_xfer  = (state == DRAIN) && out_valid && out_ready;
    assign last_row  = (out_row_idx == IW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (k_len == '0) ? FLUSH : LOAD;
            LOAD:    if (last_beat) state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = DRAIN;
            DRAIN:   if (row_xfer && last_row) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            shift_reg <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (clear) begin
                k_reg     <= k_len;
                shift_reg <= shift;
                beat_cnt  <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == FLUSH)
                flush_cnt <= flush_cnt + 1'b1;
            else
                flush_cnt <= '0;
        end
    end

    // Operand skew: lane r of A and lane c of B are delayed r (resp. c) advance
    // steps so matching k terms meet in each PE; zeros are injected outside LOAD.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
        logic signed [DATA_WIDTH-1:0] lane;
        assign lane = (state == LOAD) ? a_in[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (r == 0) begin : g_direct
            assign a_h[r][0] = lane;
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] line [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) line[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < r; i++) line[i] <= '0;
                end else if (advance) begin
                    line[0] <= lane;
                    for (int i = 1; i < r; i++) line[i] <= line[i-1];
                end
            end
            assign a_h[r][0] = line[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_skew_b
        logic signed [DATA_WIDTH-1:0] lane;
        assign lane = (state == LOAD) ? b_in[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (c == 0) begin : g_direct
            assign b_v[0][c] = lane;
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] line [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) line[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < c; i++) line[i] <= '0;
                end else if (advance) begin
                    line[0] <= lane;
                    for (int i = 1; i < c; i++) line[i] <= line[i-1];
                end
            end
            assign b_v[0][c] = line[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            systolic_os_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (advance),
                .clr   (clear),
                .a     (a_h[r][c]),
                .b     (b_v[r][c]),
                .a_fwd (a_h[r][c+1]),
                .b_fwd (b_v[r+1][c]),
                .acc   (acc_grid[r][c])
            );
        end
    end

    // The row being quantised is the one that will be presented after the next
    // load of out_row: row 0 on DRAIN entry, otherwise the successor of the current row.
    always_comb begin
        sel_row = out_valid ? out_row_idx + 1'b1 : '0;
        q_row   = '0;
        for (int c = 0; c < COLS; c++)
            q_row[c*DATA_WIDTH +: DATA_WIDTH] =
                DATA_WIDTH'(sat_round(64'(acc_grid[sel_row][c]), 32'(shift_reg), DATA_WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == DRAIN) begin
                if (!out_valid) begin
                    out_valid   <= 1'b1;
                    out_row     <= q_row;
                    out_row_idx <= '0;
                end else if (out_ready) begin
                    if (last_row) begin
                        out_valid   <= 1'b0;
                        out_row_idx <= '0;
                        done        <= 1'b1;
                    end else begin
                        out_row_idx <= out_row_idx + 1'b1;
                        out_row     <= q_row;
                    end
                end
            end
        end
    end

endmodule
